store_write_buffer: RTL and testbench
=====================================

// Module: store_write_buffer
// PURPOSE
// - Posted-store FIFO between CPU load/store path and single-port data memory.
// - CPU stores enqueue here; drained in order when memory port is free; loads use port directly.
// - Loads forward youngest matching buffered store so CPU never reads stale data.
// - Downstream side drives the data memory's MemRead/MemWrite/address/writeData, takes readData back.
// PARAMETERS
// - DEPTH   4   buffer entries (power of 2, >=2)
// - DATA_W  32  data width
// PORTS
// - clk             in   1       clock, all state on rising edge
// - reset           in   1       asynchronous, active-low; clears buffer
// - cpu_mem_read    in   1       CPU load this cycle
// - cpu_mem_write   in   1       CPU store this cycle
// - cpu_address     in   32      CPU byte address (word-aligned)
// - cpu_write_data  in   DATA_W  store data
// - cpu_read_data   out  DATA_W  load result (forwarded or memory), combinational
// - stall           out  1       store not accepted; CPU must hold instruction
// - MemRead         out  1       to data memory
// - MemWrite        out  1       to data memory
// - address         out  32      to data memory, {word_idx,2'b00}
// - writeData       out  DATA_W  to data memory
// - readData        in   DATA_W  from data memory, combinational read
// - count           out  $clog2(DEPTH)+1  occupied entries
// - empty           out  1       count==0
// BEHAVIOUR
// - Entry = {word_idx = address[31:2], data}; address[1:0] ignored. Circular FIFO, wr/rd pointers wrap mod DEPTH.
// - Reset (async, reset==0): count=0, pointers=0, empty=1, stall=0, MemRead=0, MemWrite=0, address=0, writeData=0.
// - Reset mid-operation discards all buffered stores; none reach memory.
// - Memory port mux (combinational), priority:
//   1) cpu_mem_read: MemRead=1, MemWrite=0, address=cpu_address.
//   2) drain: MemRead=0, MemWrite=1, address/writeData = head entry.
//   3) idle: MemRead=0, MemWrite=0, address/writeData = 0.
// - drain = !empty & !cpu_mem_read & (!cpu_mem_write | full). Head popped at that clk edge; memory writes same edge.
// - enqueue = cpu_mem_write & !cpu_mem_read & !full; entry written at tail at clk edge.
// - stall = cpu_mem_write & !cpu_mem_read & full. Stalled cycle drains head, so next cycle accepts: no deadlock, max 1 stall cycle per store.
// - Enqueue and drain never coincide (drain with a store only when full, where enqueue is blocked); count changes by at most 1/cycle.
// - Drain order strictly FIFO; memory sees stores in program order.
// - Load forwarding: compare cpu_address[31:2] against all valid entries; youngest match -> cpu_read_data = entry data; no match -> readData. Zero added latency.
// - cpu_mem_read & cpu_mem_write both 1: illegal; treated as load only, store dropped, stall=0.
// - Stores while empty still enqueue (1-cycle post), drained next cycle without CPU access.
// - count never exceeds DEPTH; empty and full derived from count.
// TESTING
// - Reset, 4 stores addr 0x0,0x4,0x8,0xC data 11..14 back-to-back -> count 1,2,3,4, MemWrite=0 throughout, stall=0.
// - 5th store (0x10,15) with count=4 -> stall=1 one cycle, MemWrite=1 address=0x0 writeData=11; next cycle accepted, count=4.
// - Stores 0x20=5 then 0x20=9 buffered, load 0x20 -> cpu_read_data=9, MemRead=1, no drain that cycle.
// - Load 0x24 not buffered, memory holds 6 -> cpu_read_data=6; buffer count unchanged.
// - Idle cycles after 3 stores -> MemWrite pulses 3 cycles, addresses in issue order, then empty=1.
// - reset low while count=3 mid-drain -> count=0, MemWrite=0 immediately; later load of those addresses returns memory value.

Source files
------------

// File: rtl/store_write_buffer.sv
// Posted-store write buffer between the CPU load/store path and a single-port data memory.
// Stores drain in order when the port is idle; loads bypass the buffer and forward the youngest match.
module store_write_buffer #(
    parameter  int unsigned DEPTH  = 4,
    parameter  int unsigned DATA_W = 32,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_mem_read,
    input  logic              cpu_mem_write,
    input  logic [31:0]       cpu_address,
    input  logic [DATA_W-1:0] cpu_write_data,
    output logic [DATA_W-1:0] cpu_read_data,
    output logic              stall,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [31:0]       address,
    output logic [DATA_W-1:0] writeData,
    input  logic [DATA_W-1:0] readData,
    output logic [CNT_W-1:0]  count,
    output logic              empty
);

    logic [29:0]       idx_q  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic full;
    logic is_empty;
    logic do_load;
    logic do_enq;
    logic do_drain;

    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [PTR_W-1:0]  slot;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign is_empty = (count_q == '0);

    // An illegal read+write is treated as a load; the store is dropped without a stall.
    assign do_load  = reset & cpu_mem_read;
    assign do_enq   = cpu_mem_write & ~cpu_mem_read & ~full;
    assign do_drain = ~is_empty & ~cpu_mem_read & (~cpu_mem_write | full);

    assign stall = reset & cpu_mem_write & ~cpu_mem_read & full;
    assign count = count_q;
    assign empty = is_empty;

    always_comb begin
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        address   = '0;
        writeData = '0;
        if (do_load) begin
            MemRead = 1'b1;
            address = cpu_address;
        end else if (do_drain) begin
            MemWrite  = 1'b1;
            address   = {idx_q[rd_ptr_q], 2'b00};
            writeData = data_q[rd_ptr_q];
        end
    end

    // Walk oldest to youngest so the last valid match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        slot     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (idx_q[slot] == cpu_address[31:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[slot];
            end
        end
    end

    assign cpu_read_data = fwd_hit ? fwd_data : readData;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_enq) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
        end else if (do_drain) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset; validity comes from the pointers and count.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            idx_q[wr_ptr_q]  <= cpu_address[31:2];
            data_q[wr_ptr_q] <= cpu_write_data;
        end
    end

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: queue-based reference model plus a simple
// behavioural data memory on the downstream port.
module tb_store_write_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_mem_read, cpu_mem_write;
    logic [31:0] cpu_address, cpu_write_data, cpu_read_data;
    logic        stall, MemRead, MemWrite;
    logic [31:0] address, writeData, readData;
    logic [2:0]  count;
    logic        empty;

    always #5 clk = ~clk;

    store_write_buffer #(.DEPTH(4), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
        .cpu_address(cpu_address), .cpu_write_data(cpu_write_data),
        .cpu_read_data(cpu_read_data), .stall(stall),
        .MemRead(MemRead), .MemWrite(MemWrite), .address(address),
        .writeData(writeData), .readData(readData),
        .count(count), .empty(empty)
    );

    logic [31:0] dev_mem [256];
    assign readData = dev_mem[address[9:2]];
    always @(posedge clk) if (MemWrite) dev_mem[address[9:2]] <= writeData;

    typedef struct packed { logic [29:0] idx; logic [31:0] data; } ent_t;
    ent_t        q[$];
    logic [31:0] ref_mem [256];

    int n_pass = 0;
    int n_total = 0;

    logic        cur_rd, cur_wr;
    logic [31:0] cur_addr, cur_data;
    logic        exp_mr, exp_mw, exp_stall, exp_empty;
    logic [31:0] exp_addr, exp_wd, exp_rdata;
    logic [2:0]  exp_count;

    function automatic logic [31:0] model_load(input logic [31:0] a);
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].idx == a[31:2]) return q[i].data;
        return ref_mem[a[9:2]];
    endfunction

    // Apply inputs shortly after the rising edge and derive what the port must show this cycle.
    task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        logic full;
        cpu_mem_read = rd; cpu_mem_write = wr; cpu_address = a; cpu_write_data = d;
        cur_rd = rd; cur_wr = wr; cur_addr = a; cur_data = d;
        #2;
        full      = (q.size() == 4);
        exp_mr    = rd;
        exp_mw    = !rd && (q.size() > 0) && (!wr || full);
        exp_stall = wr && !rd && full;
        exp_addr  = rd ? a : (exp_mw ? {q[0].idx, 2'b00} : 32'h0);
        exp_wd    = exp_mw ? q[0].data : 32'h0;
        exp_rdata = model_load(a);
        exp_count = 3'(q.size());
        exp_empty = (q.size() == 0);
    endtask

    task automatic advance();
        logic full;
        full = (q.size() == 4);
        @(posedge clk);
        if (exp_mw) begin
            ref_mem[q[0].idx[7:0]] = q[0].data;
            void'(q.pop_front());
        end else if (cur_wr && !cur_rd && !full) begin
            q.push_back({cur_addr[31:2], cur_data});
        end
        #1;
    endtask

    task automatic idle_until_empty();
        for (int i = 0; i < 8 && q.size() > 0; i++) begin
            drive(1'b0, 1'b0, 32'h0, 32'h0);
            advance();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cpu_mem_read = 1'b0; cpu_mem_write = 1'b1; cpu_address = 32'h4; cpu_write_data = 32'h55;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", count); else n_pass++;
        n_total++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b expected 1", empty); else n_pass++;
        n_total++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall); else n_pass++;
        n_total++; if ({MemRead, MemWrite} !== 2'b00) $display("FAIL reset_memctl: got %b expected 00", {MemRead, MemWrite}); else n_pass++;
        n_total++; if ({address, writeData} !== 64'h0) $display("FAIL reset_addr_data: got %h expected 0", {address, writeData}); else n_pass++;
        cpu_mem_write = 1'b0;
        reset = 1'b1;
        q.delete();
    endtask

    task automatic test_fill_and_stall();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 32'(i * 4), 32'(11 + i));
            n_total++; if (count !== 3'(i)) $display("FAIL fill_count: got %0d expected %0d", count, i); else n_pass++;
            n_total++; if ({stall, MemWrite} !== 2'b00) $display("FAIL fill_no_drain: got %b expected 00", {stall, MemWrite}); else n_pass++;
            advance();
        end
        drive(1'b0, 1'b1, 32'h10, 32'd15);
        n_total++; if (stall !== 1'b1) $display("FAIL full_stall: got %b expected 1", stall); else n_pass++;
        n_total++; if (MemWrite !== 1'b1) $display("FAIL full_drain_we: got %b expected 1", MemWrite); else n_pass++;
        n_total++; if (address !== 32'h0) $display("FAIL full_drain_addr: got %h expected 0", address); else n_pass++;
        n_total++; if (writeData !== 32'd11) $display("FAIL full_drain_data: got %0d expected 11", writeData); else n_pass++;
        advance();
        drive(1'b0, 1'b1, 32'h10, 32'd15);
        n_total++; if ({stall, MemWrite} !== 2'b00) $display("FAIL retry_accept: got %b expected 00", {stall, MemWrite}); else n_pass++;
        n_total++; if (count !== 3'd3) $display("FAIL retry_count: got %0d expected 3", count); else n_pass++;
        advance();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        n_total++; if (count !== 3'd4) $display("FAIL after_retry_count: got %0d expected 4", count); else n_pass++;
        n_total++; if (address !== 32'h4 || writeData !== 32'd12) $display("FAIL drain_order: got %h/%0d expected 4/12", address, writeData); else n_pass++;
        advance();
        idle_until_empty();
        n_total++; if (empty !== 1'b1) $display("FAIL fill_drained_empty: got %b expected 1", empty); else n_pass++;
    endtask

    task automatic test_forward();
        drive(1'b0, 1'b1, 32'h20, 32'd5); advance();
        drive(1'b0, 1'b1, 32'h20, 32'd9); advance();
        drive(1'b1, 1'b0, 32'h20, 32'h0);
        n_total++; if (cpu_read_data !== 32'd9) $display("FAIL fwd_youngest: got %0d expected 9", cpu_read_data); else n_pass++;
        n_total++; if ({MemRead, MemWrite} !== 2'b10) $display("FAIL fwd_memctl: got %b expected 10", {MemRead, MemWrite}); else n_pass++;
        n_total++; if (address !== 32'h20) $display("FAIL fwd_addr: got %h expected 20", address); else n_pass++;
        advance();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        n_total++; if (count !== 3'd2) $display("FAIL fwd_no_drain: got %0d expected 2", count); else n_pass++;
        advance();
        idle_until_empty();
    endtask

    task automatic test_load_miss();
        dev_mem[9] = 32'd6; ref_mem[9] = 32'd6;
        drive(1'b0, 1'b1, 32'h28, 32'd7); advance();
        drive(1'b1, 1'b0, 32'h24, 32'h0);
        n_total++; if (cpu_read_data !== 32'd6) $display("FAIL miss_data: got %0d expected 6", cpu_read_data); else n_pass++;
        advance();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        n_total++; if (count !== 3'd1) $display("FAIL miss_count: got %0d expected 1", count); else n_pass++;
        advance();
        idle_until_empty();
    endtask

    task automatic test_drain_idle();
        logic [31:0] d [3];
        for (int i = 0; i < 3; i++) begin
            d[i] = $urandom;
            drive(1'b0, 1'b1, 32'h30 + 32'(i * 4), d[i]); advance();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 32'h0, 32'h0);
            n_total++; if (MemWrite !== 1'b1) $display("FAIL idle_drain_we: got %b expected 1", MemWrite); else n_pass++;
            n_total++; if (address !== 32'h30 + 32'(i * 4) || writeData !== d[i])
                $display("FAIL idle_drain_entry: got %h/%h expected %h/%h", address, writeData, 32'h30 + 32'(i * 4), d[i]);
            else n_pass++;
            advance();
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        n_total++; if ({MemWrite, empty} !== 2'b01) $display("FAIL idle_done: got %b expected 01", {MemWrite, empty}); else n_pass++;
        n_total++; if (dev_mem[14] !== d[2]) $display("FAIL idle_mem_written: got %h expected %h", dev_mem[14], d[2]); else n_pass++;
        advance();
    endtask

    task automatic test_illegal();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 32'h60 + 32'(i * 4), 32'hC0 + 32'(i)); advance();
        end
        drive(1'b1, 1'b1, 32'h64, 32'hDEAD);
        n_total++; if ({stall, MemRead, MemWrite} !== 3'b010) $display("FAIL illegal_ctl: got %b expected 010", {stall, MemRead, MemWrite}); else n_pass++;
        n_total++; if (cpu_read_data !== 32'hC1) $display("FAIL illegal_fwd: got %h expected c1", cpu_read_data); else n_pass++;
        advance();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        n_total++; if (count !== 3'd4) $display("FAIL illegal_count: got %0d expected 4", count); else n_pass++;
        advance();
        idle_until_empty();
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 32'h40 + 32'(i * 4), 32'hA0 + 32'(i)); advance();
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0); advance();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        n_total++; if ({count, MemWrite} !== {3'd3, 1'b1}) $display("FAIL mid_drain_state: got %0d/%b expected 3/1", count, MemWrite); else n_pass++;
        reset = 1'b0;
        #1;
        n_total++; if (count !== 3'd0) $display("FAIL rst_mid_count: got %0d expected 0", count); else n_pass++;
        n_total++; if ({MemWrite, empty} !== 2'b01) $display("FAIL rst_mid_ctl: got %b expected 01", {MemWrite, empty}); else n_pass++;
        q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 1; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'h40 + 32'(i * 4), 32'h0);
            n_total++; if (cpu_read_data !== exp_rdata) $display("FAIL rst_discard_load: got %h expected %h", cpu_read_data, exp_rdata); else n_pass++;
            advance();
        end
        n_total++; if (ref_mem[16] !== 32'hA0) $display("FAIL rst_first_drained: got %h expected a0", dev_mem[16]); else n_pass++;
    endtask

    task automatic test_random();
        logic rd, wr;
        for (int c = 0; c < 400; c++) begin
            rd = ($urandom_range(0, 9) < 3);
            wr = ($urandom_range(0, 9) < 6);
            drive(rd, wr, {24'h0, 2'b0, 4'($urandom_range(0, 15)), 2'b00}, $urandom);
            n_total++;
            if ({stall, MemRead, MemWrite, count, empty} !== {exp_stall, exp_mr, exp_mw, exp_count, exp_empty})
                $display("FAIL rnd_ctl: got %b expected %b", {stall, MemRead, MemWrite, count, empty},
                         {exp_stall, exp_mr, exp_mw, exp_count, exp_empty});
            else n_pass++;
            n_total++;
            if (address !== exp_addr) $display("FAIL rnd_addr: got %h expected %h", address, exp_addr); else n_pass++;
            n_total++;
            if (rd && cpu_read_data !== exp_rdata) $display("FAIL rnd_load: got %h expected %h", cpu_read_data, exp_rdata);
            else if (!rd && writeData !== exp_wd) $display("FAIL rnd_wdata: got %h expected %h", writeData, exp_wd);
            else n_pass++;
            advance();
        end
        idle_until_empty();
        for (int i = 0; i < 16; i++) begin
            n_total++;
            if (dev_mem[i] !== ref_mem[i]) $display("FAIL rnd_mem_image[%0d]: got %h expected %h", i, dev_mem[i], ref_mem[i]);
            else n_pass++;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = $urandom;
            dev_mem[i] = ref_mem[i];
        end
        test_reset();
        test_fill_and_stall();
        test_forward();
        test_load_miss();
        test_drain_idle();
        test_illegal();
        test_reset_mid_drain();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
